// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit ALU datapath: fetches over req/ack, owns the
// register file, pc and status, drives the combinational ALU and resolves branches.
module alu_sequencer #(
  parameter int DataWidth     = 8,
  parameter int NumOpCodeBits = 5,
  parameter int ParamBits     = 8,
  parameter int NumStatusBits = 3,
  parameter int RegAddrBits   = 2,
  parameter int PcBits        = 8,
  parameter int InstrWidth    = NumOpCodeBits + 2*RegAddrBits + ParamBits
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  output logic                     instr_req,
  output logic [PcBits-1:0]        instr_addr,
  input  logic                     instr_ack,
  input  logic [InstrWidth-1:0]    instr_data,
  output logic [NumOpCodeBits-1:0] alu_opcode,
  output logic [DataWidth-1:0]     alu_operand1,
  output logic [DataWidth-1:0]     alu_operand2,
  output logic [ParamBits-1:0]     alu_param,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [NumStatusBits-1:0] alu_status,
  output logic [NumStatusBits-1:0] status,
  output logic                     busy,
  output logic                     halted,
  output logic                     illegal,
  input  logic [RegAddrBits-1:0]   dbg_addr,
  output logic [DataWidth-1:0]     dbg_data
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  localparam int NumRegs = 2**RegAddrBits;
  localparam int ZBit    = 2;
  localparam logic [NumOpCodeBits-1:0] OpNop  = NumOpCodeBits'(0);
  localparam logic [NumOpCodeBits-1:0] OpShl  = NumOpCodeBits'(7);
  localparam logic [NumOpCodeBits-1:0] OpShr  = NumOpCodeBits'(8);
  localparam logic [NumOpCodeBits-1:0] OpVal  = NumOpCodeBits'(9);
  localparam logic [NumOpCodeBits-1:0] OpGoto = NumOpCodeBits'(16);
  localparam logic [NumOpCodeBits-1:0] OpIfz  = NumOpCodeBits'(17);
  localparam logic [NumOpCodeBits-1:0] OpIfnz = NumOpCodeBits'(18);
  localparam logic [NumOpCodeBits-1:0] OpIfeq = NumOpCodeBits'(19);
  localparam logic [NumOpCodeBits-1:0] OpIfst = NumOpCodeBits'(20);
  localparam logic [NumOpCodeBits-1:0] OpIfgt = NumOpCodeBits'(21);

  function automatic logic [NumOpCodeBits-1:0] f_op(input logic [InstrWidth-1:0] w);
    return w[InstrWidth-1 -: NumOpCodeBits];
  endfunction

  function automatic logic [RegAddrBits-1:0] f_ra(input logic [InstrWidth-1:0] w);
    return w[ParamBits+RegAddrBits +: RegAddrBits];
  endfunction

  function automatic logic [RegAddrBits-1:0] f_rb(input logic [InstrWidth-1:0] w);
    return w[ParamBits +: RegAddrBits];
  endfunction

  function automatic logic [ParamBits-1:0] f_param(input logic [InstrWidth-1:0] w);
    return w[ParamBits-1:0];
  endfunction

  function automatic logic is_alu_op(input logic [NumOpCodeBits-1:0] op);
    return (op != OpNop) && (op <= OpShl);
  endfunction

  state_t                   state;
  logic [PcBits-1:0]        pc;
  logic [InstrWidth-1:0]    ir;
  logic [DataWidth-1:0]     regs [NumRegs];

  logic [NumOpCodeBits-1:0] ex_op;
  logic [RegAddrBits-1:0]   ex_ra;
  logic [RegAddrBits-1:0]   ex_rb;
  logic [ParamBits-1:0]     ex_param;
  logic [DataWidth-1:0]     ex_a;
  logic [DataWidth-1:0]     ex_b;
  logic [PcBits-1:0]        pc_inc;
  logic [PcBits-1:0]        tgt;

  assign ex_op      = f_op(ir);
  assign ex_ra      = f_ra(ir);
  assign ex_rb      = f_rb(ir);
  assign ex_param   = f_param(ir);
  assign ex_a       = regs[ex_ra];
  assign ex_b       = regs[ex_rb];
  assign pc_inc     = pc + PcBits'(1);
  assign tgt        = ex_param[PcBits-1:0];
  assign instr_addr = pc;
  assign dbg_data   = regs[dbg_addr];

  // ALU inputs are loaded on the ack edge so they are valid for the whole EXEC cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pc           <= '0;
      ir           <= '0;
      status       <= '0;
      instr_req    <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      illegal      <= 1'b0;
      alu_opcode   <= OpNop;
      alu_operand1 <= '0;
      alu_operand2 <= '0;
      alu_param    <= '0;
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            pc        <= '0;
            illegal   <= 1'b0;
            halted    <= 1'b0;
            busy      <= 1'b1;
            instr_req <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (instr_ack) begin
            ir           <= instr_data;
            instr_req    <= 1'b0;
            alu_opcode   <= is_alu_op(f_op(instr_data)) ? f_op(instr_data) : OpNop;
            alu_operand1 <= regs[f_ra(instr_data)];
            alu_operand2 <= regs[f_rb(instr_data)];
            alu_param    <= f_param(instr_data);
            state        <= EXEC;
          end
        end
        EXEC: begin
          alu_opcode   <= OpNop;
          alu_operand1 <= '0;
          alu_operand2 <= '0;
          alu_param    <= '0;
          instr_req    <= 1'b1;
          state        <= FETCH;
          pc           <= pc_inc;
          if (is_alu_op(ex_op)) begin
            regs[ex_ra] <= alu_result;
            status      <= alu_status;
          end else begin
            case (ex_op)
              OpNop, OpShr: ;
              OpVal:  regs[ex_ra] <= ex_param[DataWidth-1:0];
              OpGoto: pc <= tgt;
              OpIfz:  if (status[ZBit])   pc <= tgt;
              OpIfnz: if (!status[ZBit])  pc <= tgt;
              OpIfeq: if (ex_a == ex_b)   pc <= tgt;
              OpIfst: if (ex_a < ex_b)    pc <= tgt;
              OpIfgt: if (ex_a > ex_b)    pc <= tgt;
              default: begin
                // Reserved opcode: park on the offending address for inspection.
                pc        <= pc;
                instr_req <= 1'b0;
                busy      <= 1'b0;
                halted    <= 1'b1;
                illegal   <= 1'b1;
                state     <= HALT;
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: program memory with configurable ack latency, a behavioural
// ALU, directed vector table, multi-cycle corner sequences and random programs vs. an ISA model.
module tb_alu_sequencer;

  localparam logic [4:0] NOP = 5'd0, ADD = 5'd1, SUB = 5'd2, AND_ = 5'd3, OR_ = 5'd4;
  localparam logic [4:0] NOT_ = 5'd5, XOR_ = 5'd6, SHL = 5'd7, SHR = 5'd8, VAL = 5'd9;
  localparam logic [4:0] GOTO = 5'd16, IFZ = 5'd17, IFNZ = 5'd18, IFEQ = 5'd19;
  localparam logic [4:0] IFST = 5'd20, IFGT = 5'd21, RSV = 5'd24;
  localparam logic [16:0] HALTW = {RSV, 12'h000};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic        instr_ack;
  logic [16:0] instr_data;
  logic [4:0]  alu_opcode;
  logic [7:0]  alu_operand1, alu_operand2, alu_param, alu_result;
  logic [2:0]  alu_status, status;
  logic        busy, halted, illegal;
  logic [1:0]  dbg_addr = 2'd0;
  logic [7:0]  dbg_data;

  int n_cmp = 0;
  int n_fail = 0;

  logic [16:0] prog [256];
  int          ack_dly = 0;
  int          ack_cnt = 0;
  logic        spur_ack = 1'b0;

  always #5 clock = ~clock;

  alu_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
    .instr_data(instr_data), .alu_opcode(alu_opcode), .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2), .alu_param(alu_param), .alu_result(alu_result),
    .alu_status(alu_status), .status(status), .busy(busy), .halted(halted),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Program memory: garbage on the data bus unless the ack is up.
  assign instr_ack  = (instr_req && (ack_cnt >= ack_dly)) || spur_ack;
  assign instr_data = instr_ack ? prog[instr_addr] : 17'h1FFFF;

  always_ff @(posedge clock) begin
    if (!instr_req || instr_ack) ack_cnt <= 0;
    else                         ack_cnt <= ack_cnt + 1;
  end

  // Behavioural ALU: returns {zero, underflow, carry, result}.
  function automatic logic [10:0] alu_f(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] t;
    logic [7:0] r;
    logic c, u;
    c = 1'b0; u = 1'b0; r = 8'h00;
    case (op)
      ADD:  begin t = {1'b0, a} + {1'b0, b}; r = t[7:0]; c = t[8]; end
      SUB:  begin r = a - b; u = (a < b); end
      AND_: r = a & b;
      OR_:  r = a | b;
      NOT_: r = ~a;
      XOR_: r = a ^ b;
      SHL:  begin r = {a[6:0], 1'b0}; c = a[7]; end
      default: r = 8'h00;
    endcase
    return {(r == 8'h00), u, c, r};
  endfunction

  always_comb begin
    {alu_status, alu_result} = alu_f(alu_opcode, alu_operand1, alu_operand2);
  end

  function automatic logic [16:0] enc(input logic [4:0] op, input logic [1:0] ra,
                                      input logic [1:0] rb, input logic [7:0] p);
    return {op, ra, rb, p};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start = 1'b0;
    spur_ack = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic fill_halt();
    for (int a = 0; a < 256; a++) prog[a] = HALTW;
  endtask

  task automatic wait_halt(input string nm);
    int n;
    n = 0;
    while (!halted && n < 2000) begin
      tick();
      n++;
    end
    if (!halted) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: halt timeout got busy=%0d expected halted=1", nm, busy);
    end
  endtask

  task automatic run_to_halt(input string nm);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_halt(nm);
  endtask

  // ISA-level reference interpreter.
  logic [7:0] m_r [4];
  logic [7:0] m_pc;
  logic [2:0] m_st;

  task automatic model_run();
    logic [16:0] w;
    logic [4:0]  op;
    logic [1:0]  ra, rb;
    logic [7:0]  p, a, b;
    logic [10:0] res;
    logic        jmp, stop;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_pc = 8'h00;
    m_st = 3'b000;
    stop = 1'b0;
    for (int s = 0; s < 400 && !stop; s++) begin
      w = prog[m_pc];
      {op, ra, rb, p} = w;
      a = m_r[ra];
      b = m_r[rb];
      jmp = 1'b0;
      if (op >= ADD && op <= SHL) begin
        res = alu_f(op, a, b);
        m_r[ra] = res[7:0];
        m_st = res[10:8];
      end else if (op == VAL) m_r[ra] = p;
      else if (op == GOTO) jmp = 1'b1;
      else if (op == IFZ)  jmp = m_st[2];
      else if (op == IFNZ) jmp = !m_st[2];
      else if (op == IFEQ) jmp = (a == b);
      else if (op == IFST) jmp = (a < b);
      else if (op == IFGT) jmp = (a > b);
      else if (op != NOP && op != SHR) stop = 1'b1;
      if (!stop) m_pc = jmp ? p : m_pc + 8'd1;
    end
  endtask

  typedef struct {
    logic [7:0]  a, b;
    logic [16:0] w1, w2;
    logic [7:0]  pc, r0, r1;
    logic [2:0]  st;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [7:0] v;
    logic [4:0] op;
    int k;

    tbl[0]  = '{8'd5,   8'd3,   enc(ADD, 0, 1, 0),     enc(NOP, 0, 0, 0),     8'd4,    8'd8,   8'd3,   3'b000};
    tbl[1]  = '{8'd200, 8'd100, enc(ADD, 0, 1, 0),     enc(SUB, 1, 1, 0),     8'd4,    8'd44,  8'd0,   3'b100};
    tbl[2]  = '{8'd200, 8'd100, enc(SUB, 1, 1, 0),     enc(IFZ, 0, 0, 8'h40), 8'h40,   8'd200, 8'd0,   3'b100};
    tbl[3]  = '{8'd3,   8'd9,   enc(IFST, 0, 1, 8'h40), enc(NOP, 0, 0, 0),    8'h40,   8'd3,   8'd9,   3'b000};
    tbl[4]  = '{8'd3,   8'd9,   enc(IFGT, 0, 1, 8'h40), enc(NOP, 0, 0, 0),    8'd4,    8'd3,   8'd9,   3'b000};
    tbl[5]  = '{8'd3,   8'd9,   enc(IFEQ, 0, 0, 8'h40), enc(NOP, 0, 0, 0),    8'h40,   8'd3,   8'd9,   3'b000};
    tbl[6]  = '{8'd5,   8'd3,   enc(SUB, 0, 1, 0),     enc(IFNZ, 0, 0, 8'h50), 8'h50,  8'd2,   8'd3,   3'b000};
    tbl[7]  = '{8'd3,   8'd5,   enc(SUB, 0, 1, 0),     enc(IFZ, 0, 0, 8'h50), 8'd4,    8'd254, 8'd5,   3'b010};
    tbl[8]  = '{8'd8,   8'd1,   enc(SHR, 0, 1, 0),     enc(GOTO, 0, 0, 8'h22), 8'h22,  8'd8,   8'd1,   3'b000};
    tbl[9]  = '{8'hF0,  8'h00,  enc(VAL, 1, 0, 8'hAB), enc(NOT_, 0, 0, 0),    8'd4,    8'h0F,  8'hAB,  3'b000};
    tbl[10] = '{8'h81,  8'd7,   enc(SHL, 0, 0, 0),     enc(XOR_, 1, 1, 0),    8'd4,    8'h02,  8'h00,  3'b100};
    tbl[11] = '{8'hF0,  8'h3C,  enc(AND_, 0, 1, 0),    enc(OR_, 1, 0, 0),     8'd4,    8'h30,  8'h3C,  3'b000};
    tbl[12] = '{8'd1,   8'd2,   enc(5'd10, 0, 1, 0),   enc(NOP, 0, 0, 0),     8'd2,    8'd1,   8'd2,   3'b000};
    tbl[13] = '{8'd9,   8'd9,   enc(IFEQ, 0, 1, 8'h60), enc(IFGT, 1, 0, 8'h70), 8'h60, 8'd9,   8'd9,   3'b000};
    tbl[14] = '{8'd9,   8'd3,   enc(IFST, 0, 1, 8'h40), enc(NOP, 0, 0, 0),    8'd4,    8'd9,   8'd3,   3'b000};

    // Reset state
    fill_halt();
    reset_n = 1'b0;
    #2;
    chk("rst_req", instr_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_aluop", alu_opcode, 0);
    chk("rst_status", status, 0);
    chk("rst_pc", instr_addr, 0);
    rd(2'd3, v); chk("rst_r3", v, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_ack_ignored", busy, 0);

    // Back-to-back VAL, VAL, ADD with immediate ack
    prog[0] = enc(VAL, 0, 0, 8'd5);
    prog[1] = enc(VAL, 1, 0, 8'd3);
    prog[2] = enc(ADD, 0, 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("seqA_req_e1", instr_req, 1);
    chk("seqA_busy", busy, 1);
    for (int i = 2; i <= 7; i++) begin
      tick();
      chk($sformatf("seqA_req_e%0d", i), instr_req, (i % 2));
    end
    chk("seqA_pc3", instr_addr, 8'd3);
    rd(2'd0, v); chk("seqA_r0", v, 8'd8);
    chk("seqA_status", status, 3'b000);
    wait_halt("seqA");

    // Vector table
    for (int t = 0; t < 15; t++) begin
      do_reset();
      fill_halt();
      ack_dly = t % 3;
      prog[0] = enc(VAL, 0, 0, tbl[t].a);
      prog[1] = enc(VAL, 1, 0, tbl[t].b);
      prog[2] = tbl[t].w1;
      prog[3] = tbl[t].w2;
      run_to_halt($sformatf("vec%0d", t));
      chk($sformatf("vec%0d_pc", t), instr_addr, tbl[t].pc);
      rd(2'd0, v); chk($sformatf("vec%0d_r0", t), v, tbl[t].r0);
      rd(2'd1, v); chk($sformatf("vec%0d_r1", t), v, tbl[t].r1);
      chk($sformatf("vec%0d_st", t), status, tbl[t].st);
      chk($sformatf("vec%0d_ill", t), illegal, 1);
    end

    // Delayed ack with garbage bus, plus a spurious ack while executing
    do_reset();
    fill_halt();
    prog[0] = enc(VAL, 0, 0, 8'h11);
    prog[1] = enc(VAL, 1, 0, 8'h22);
    ack_dly = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("dly_req_c%0d", i), instr_req, 1);
      chk($sformatf("dly_addr_c%0d", i), instr_addr, 0);
      chk($sformatf("dly_halt_c%0d", i), halted, 0);
      if (i < 5) tick();
    end
    tick();
    chk("dly_exec_req", instr_req, 0);
    spur_ack = 1'b1;
    tick();
    spur_ack = 1'b0;
    chk("dly_next_addr", instr_addr, 8'd1);
    chk("dly_next_req", instr_req, 1);
    wait_halt("dly");
    chk("dly_halt_pc", instr_addr, 8'd2);
    rd(2'd0, v); chk("dly_r0", v, 8'h11);
    rd(2'd1, v); chk("dly_r1", v, 8'h22);

    // Reserved opcode at pc 7, then restart
    do_reset();
    fill_halt();
    ack_dly = 0;
    prog[0] = enc(VAL, 0, 0, 8'h5A);
    prog[1] = enc(VAL, 3, 0, 8'h77);
    for (int a = 2; a < 7; a++) prog[a] = enc(NOP, 0, 0, 0);
    prog[7] = enc(5'b11000, 1, 2, 8'h33);
    run_to_halt("ill");
    chk("ill_halted", halted, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_busy", busy, 0);
    chk("ill_pc", instr_addr, 8'd7);
    rd(2'd0, v); chk("ill_r0", v, 8'h5A);
    rd(2'd1, v); chk("ill_r1", v, 8'h00);
    rd(2'd3, v); chk("ill_r3", v, 8'h77);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_illegal", illegal, 0);
    chk("restart_halted", halted, 0);
    chk("restart_busy", busy, 1);
    chk("restart_pc", instr_addr, 8'd0);
    wait_halt("restart");

    // pc wrap through 0xFF, then reset in the middle of a fetch
    do_reset();
    fill_halt();
    prog[0]     = enc(VAL, 2, 0, 8'h99);
    prog[1]     = enc(GOTO, 0, 0, 8'hFF);
    prog[8'hFF] = enc(NOP, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("wrap_addr_ff", instr_addr, 8'hFF);
    tick();
    tick();
    chk("wrap_addr_00", instr_addr, 8'h00);
    ack_dly = 10;
    tick();
    rd(2'd2, v); chk("wrap_r2", v, 8'h99);
    reset_n = 1'b0;
    #1;
    chk("midrst_req", instr_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pc", instr_addr, 0);
    rd(2'd2, v); chk("midrst_r2", v, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();

    // Random forward-branching programs against the ISA model
    for (int n = 0; n < 20; n++) begin
      do_reset();
      fill_halt();
      ack_dly = $urandom_range(0, 2);
      for (int a = 0; a < 40; a++) begin
        k = $urandom_range(0, 15);
        op = 5'(k < 10 ? k : k + 6);
        if (op >= GOTO)
          prog[a] = enc(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(a + 1, 47)));
        else
          prog[a] = enc(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end
      model_run();
      run_to_halt($sformatf("rnd%0d", n));
      chk($sformatf("rnd%0d_pc", n), instr_addr, m_pc);
      chk($sformatf("rnd%0d_st", n), status, m_st);
      for (int r = 0; r < 4; r++) begin
        rd(2'(r), v);
        chk($sformatf("rnd%0d_r%0d", n, r), v, m_r[r]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Instruction sequencer for the 8-bit ALU datapath.
- Fetches instructions from an external program memory over a req/ack handshake, keeps the register file, program counter and status register, and drives the combinational ALU.
- Writes back ALU results and resolves program-flow opcodes (GOTO, IFZ, IFNZ, IFEQ, IFST, IFGT) and VAL.
- Sits between program memory and ALU as the core control unit of the 8-bit processor.

Parameters:
- DataWidth, 8, register/ALU data width
- NumOpCodeBits, 5, opcode width
- ParamBits, 8, immediate/branch-target width
- NumStatusBits, 3, status width (bit0 Carry, bit1 Underflow, bit2 Zero)
- RegAddrBits, 2, register index width (2^RegAddrBits registers)
- PcBits, 8, program counter width
- InstrWidth, 17, NumOpCodeBits+2*RegAddrBits+ParamBits

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  start/restart pulse
- instr_req  out  1  fetch request
- instr_addr  out  PcBits  fetch address (= pc)
- instr_ack  in  1  instr_data valid this cycle
- instr_data  in  InstrWidth  {opcode, ra, rb, param}, opcode in MSBs
- alu_opcode  out  NumOpCodeBits  to ALU
- alu_operand1  out  DataWidth  reg[ra]
- alu_operand2  out  DataWidth  reg[rb]
- alu_param  out  ParamBits  param field
- alu_result  in  DataWidth  from ALU (combinational)
- alu_status  in  NumStatusBits  from ALU (combinational)
- status  out  NumStatusBits  registered status flags
- busy  out  1  state is FETCH or EXEC
- halted  out  1  state is HALT
- illegal  out  1  sticky; set when halted on a reserved opcode
- dbg_addr  in  RegAddrBits  debug register select
- dbg_data  out  DataWidth  reg[dbg_addr], combinational

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; pc, ir, all registers, status = 0.
  - instr_req, busy, halted, illegal = 0.
  - alu_opcode = NOP (5'b0_0000).
- States: IDLE, FETCH, EXEC, HALT.
- IDLE / HALT:
  - On start=1: pc<=0, illegal<=0, go to FETCH.
  - Registers and status retained.
  - start while busy is ignored.
- FETCH:
  - instr_req=1, instr_addr=pc; held until instr_ack.
  - On instr_ack: ir<=instr_data, go to EXEC.
  - instr_ack outside FETCH is ignored.
- EXEC: exactly one cycle; ALU outputs sampled at the end of the cycle.
  - alu_opcode = ir opcode only for 0_0001..0_0111; otherwise NOP.
  - alu_operand1/2 = reg[ra]/reg[rb]; alu_param = ir param.
  - Outside EXEC, ALU inputs are NOP / 0.
- Opcode actions in EXEC (pc+1 unless noted; then FETCH):
  - NOP: no writes.
  - ADD, SUB, AND, OR, NOT, XOR, SHL: reg[ra]<=alu_result, status<=alu_status.
  - SHR (0_1000): treated as NOP.
  - VAL (0_1001): reg[ra]<=param[DataWidth-1:0]; status unchanged.
  - GOTO: pc<=param[PcBits-1:0].
  - IFZ: jump if status[2]=1.
  - IFNZ: jump if status[2]=0.
  - IFEQ: jump if reg[ra]==reg[rb] (unsigned).
  - IFST: jump if reg[ra]<reg[rb] (unsigned).
  - IFGT: jump if reg[ra]>reg[rb] (unsigned).
  - Branches never modify status or registers.
  - Reserved 0_1010..0_1111 and 1_0110..1_1111: illegal<=1, go to HALT, pc holds the offending address.
- pc increments modulo 2^PcBits (255 -> 0 wrap).
- Throughput: one instruction per (ack latency + 2) cycles minimum (FETCH 1 cycle with immediate ack, EXEC 1 cycle).
- ra==rb is legal for all ops (operand1 = operand2 = same register).
- Reset asserted mid-FETCH or mid-EXEC: immediate abort, no partial writeback; instr_req drops asynchronously.

Test Plan:
- Reset, start pulse, program VAL r0,5; VAL r1,3; ADD r0,r1; ack same cycle -> r0=8, status=000, pc=3 after 6 cycles; instr_req deasserts only in EXEC.
- VAL r0,200; VAL r1,100; ADD r0,r1 -> r0=44, status[0]=1; then SUB r1,r1 -> r1=0, status=100; IFZ 0x10 -> next instr_addr=0x10.
- VAL r2,3; VAL r3,9; IFST r2,r3 to 0x40 -> taken; IFGT r2,r3 -> not taken, pc+1; IFEQ r2,r2 -> taken.
- Ack delayed 4 cycles -> instr_req/instr_addr stable throughout, ir captured only on the ack cycle; spurious instr_ack during EXEC ignored.
- Opcode 1_1000 at pc=7 -> halted=1, illegal=1, pc=7, registers unchanged; start -> restart at pc=0, illegal=0.
- GOTO 0xFF then NOP at 0xFF -> next fetch at 0x00; reset_n low mid-FETCH -> instr_req=0 immediately, state IDLE, all regs 0.
